// File: rtl/neuron_row_mac_if.sv
// rtl/neuron_row_mac_if.sv - pixel stream, weight-bank read port and result bus of one neuron row MAC
interface neuron_row_mac_if #(
  parameter int ADDR_W = 5,
  parameter int D_W    = 16,
  parameter int ACC_W  = 40
);
  logic              START;
  logic [D_W-1:0]    X_IN;
  logic              X_VALID;
  logic              X_READY;
  logic [ADDR_W-1:0] W_ADDR;
  logic              W_EN;
  logic              W_WE;
  logic [D_W-1:0]    W_DI;
  logic [D_W-1:0]    W_DO;
  logic              BUSY;
  logic              DONE;
  logic [D_W-1:0]    RESULT;
  logic [ACC_W-1:0]  ACC_OUT;

  modport master (
    input  START, X_IN, X_VALID, W_DO,
    output X_READY, W_ADDR, W_EN, W_WE, W_DI, BUSY, DONE, RESULT, ACC_OUT
  );

  modport slave (
    output START, X_IN, X_VALID, W_DO,
    input  X_READY, W_ADDR, W_EN, W_WE, W_DI, BUSY, DONE, RESULT, ACC_OUT
  );
endinterface

// File: rtl/neuron_row_mac.sv
// rtl/neuron_row_mac.sv - streams one 28-entry weight bank against input pixels, returns a Q8.8 saturated dot product
module neuron_row_mac #(
  parameter int N_W    = 28,
  parameter int ADDR_W = 5,
  parameter int D_W    = 16,
  parameter int ACC_W  = 40
) (
  input  logic CLK,
  input  logic RST_N,
  neuron_row_mac_if.master bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE_ST} state_t;

  localparam logic [ADDR_W-1:0]       LAST_ADDR = ADDR_W'(N_W - 1);
  localparam logic signed [ACC_W-1:0] SAT_MAX   = ACC_W'((2 ** (D_W - 1)) - 1);
  localparam logic signed [ACC_W-1:0] SAT_MIN   = -SAT_MAX - 1;

  state_t                   state, state_next;
  logic [ADDR_W-1:0]        count;
  logic signed [ACC_W-1:0]  acc;
  logic signed [D_W-1:0]    x_reg;
  logic                     mac_pend;
  logic [D_W-1:0]           result_r;
  logic [ACC_W-1:0]         acc_out_r;

  logic                     ready;
  logic                     hs;
  logic signed [2*D_W-1:0]  prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  shifted;
  logic [D_W-1:0]           result_sat;

  assign ready    = (state == RUN);
  assign hs       = ready & bus.X_VALID;
  assign prod     = x_reg * $signed(bus.W_DO);
  assign prod_ext = {{(ACC_W - 2*D_W){prod[2*D_W-1]}}, prod};
  assign shifted  = acc >>> 8;

  always_comb begin
    result_sat = shifted[D_W-1:0];
    if (shifted > SAT_MAX)
      result_sat = SAT_MAX[D_W-1:0];
    else if (shifted < SAT_MIN)
      result_sat = SAT_MIN[D_W-1:0];
  end

  // DRAIN lingers until the last pending product has landed in acc, so the snapshot is always complete
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.START) state_next = RUN;
      RUN:     if (hs && count == LAST_ADDR) state_next = DRAIN;
      DRAIN:   if (!mac_pend) state_next = DONE_ST;
      DONE_ST: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count     <= '0;
      acc       <= '0;
      x_reg     <= '0;
      mac_pend  <= 1'b0;
      result_r  <= '0;
      acc_out_r <= '0;
    end else begin
      mac_pend <= hs;
      if (state == IDLE && bus.START) begin
        acc   <= '0;
        count <= '0;
      end else if (mac_pend) begin
        acc <= acc + prod_ext;
      end
      if (hs) begin
        x_reg <= $signed(bus.X_IN);
        if (count != LAST_ADDR)
          count <= count + 1'b1;
      end
      if (state == DRAIN && !mac_pend) begin
        acc_out_r <= acc;
        result_r  <= result_sat;
      end
    end
  end

  assign bus.X_READY = ready;
  assign bus.W_EN    = hs;
  assign bus.W_ADDR  = count;
  assign bus.W_WE    = 1'b0;
  assign bus.W_DI    = '0;
  assign bus.BUSY    = (state == RUN) || (state == DRAIN);
  assign bus.DONE    = (state == DONE_ST);
  assign bus.RESULT  = result_r;
  assign bus.ACC_OUT = acc_out_r;

endmodule
